// File: rtl/mmio_bridge.sv
// CPU-side MMIO bridge: splits the bus between DRAM and a small peripheral page
// (7-seg scanner, LEDs, switches, optional timer enabled by MMIO_BRIDGE_TIMER_EN).
module mmio_bridge #(
  parameter int unsigned SCAN_DIV  = 20000,
  parameter int unsigned TIMER_DIV = 25000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] Bus_addr,
  input  logic        Bus_wen,
  input  logic [31:0] Bus_wdata,
  output logic [31:0] Bus_rdata,
  output logic [13:0] dram_addr,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int unsigned SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W     = 3;
  localparam logic [11:0] OFF_DIG   = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_TDIV  = 12'h024;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;

  logic              periph;
  logic [11:0]       off;
  logic              wr_ok;
  logic              wr_dig;
  logic              wr_led;
  logic              wr_timer;
  logic              wr_tdiv;
  logic [31:0]       dig_reg;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic [31:0]       timer_rd;
  logic [31:0]       tdiv_rd;

  assign periph     = (Bus_addr[31:12] == 20'hFFFFF);
  assign off        = Bus_addr[11:0];
  assign dram_addr  = Bus_addr[15:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen & ~periph;

  // Peripheral writes are suppressed while reset is held
  assign wr_ok    = Bus_wen & periph & ~cpu_rst;
  assign wr_dig   = wr_ok & (off == OFF_DIG);
  assign wr_led   = wr_ok & (off == OFF_LED);
  assign wr_timer = wr_ok & (off == OFF_TIMER);
  assign wr_tdiv  = wr_ok & (off == OFF_TDIV);

  function automatic logic [7:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
  endfunction

  // Writable display/LED registers
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dig_reg <= 32'd0;
      led     <= 24'd0;
    end else begin
      if (wr_dig) dig_reg <= Bus_wdata;
      if (wr_led) led     <= Bus_wdata[23:0];
    end
  end

  // Digit scanner: outputs latch only at slot start, so DIG writes appear at the next slot
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      dig_en   <= 8'hFF;
      dig_seg  <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= dig_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      if (scan_cnt == '0) begin
        dig_en  <= ~(8'd1 << dig_idx);
        dig_seg <= seg7(dig_reg[{dig_idx, 2'b00} +: 4]);
      end
    end
  end

`ifdef MMIO_BRIDGE_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] tdiv_q;
  logic [31:0] tpre_q;
  logic        tick;

  assign tick     = (tdiv_q != 32'd0) && (tpre_q == tdiv_q - 32'd1);
  assign timer_rd = timer_q;
  assign tdiv_rd  = tdiv_q;

  // Free-running timer; a CPU write to TIMER takes priority over a tick
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      timer_q <= 32'd0;
      tdiv_q  <= 32'(TIMER_DIV);
      tpre_q  <= 32'd0;
    end else begin
      if (wr_timer)  timer_q <= Bus_wdata;
      else if (tick) timer_q <= timer_q + 32'd1;
      if (wr_tdiv) tdiv_q <= Bus_wdata;
      if (wr_timer || wr_tdiv || tick) tpre_q <= 32'd0;
      else if (tdiv_q != 32'd0)        tpre_q <= tpre_q + 32'd1;
    end
  end
`else
  logic unused_timer;

  assign timer_rd     = 32'd0;
  assign tdiv_rd      = 32'd0;
  assign unused_timer = ^{32'(TIMER_DIV), wr_timer, wr_tdiv};
`endif

  // Same-cycle read mux
  always_comb begin
    Bus_rdata = dram_rdata;
    if (periph) begin
      case (off)
        OFF_DIG:   Bus_rdata = dig_reg;
        OFF_TIMER: Bus_rdata = timer_rd;
        OFF_TDIV:  Bus_rdata = tdiv_rd;
        OFF_LED:   Bus_rdata = {8'd0, led};
        OFF_SW:    Bus_rdata = {8'd0, sw};
        default:   Bus_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: stimulus queues expected values tagged with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_mmio_bridge;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned TIMER_DIV = 7;

  localparam int S_RDATA = 0;
  localparam int S_DWEN  = 1;
  localparam int S_DADDR = 2;
  localparam int S_DWDAT = 3;
  localparam int S_LED   = 4;
  localparam int S_DEN   = 5;
  localparam int S_DSEG  = 6;

  localparam logic [31:0] A_DIG   = 32'hFFFFF000;
  localparam logic [31:0] A_TIMER = 32'hFFFFF020;
  localparam logic [31:0] A_TDIV  = 32'hFFFFF024;
  localparam logic [31:0] A_LED   = 32'hFFFFF060;
  localparam logic [31:0] A_SW    = 32'hFFFFF070;
  localparam logic [31:0] A_UNMAP = 32'hFFFFF040;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  int unsigned cyc  = 0;
  int unsigned base = 0;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  chk_t        sb[$];
  chk_t        e;
  logic [31:0] act;

  mmio_bridge #(.SCAN_DIV(SCAN_DIV), .TIMER_DIV(TIMER_DIV)) dut (
    .cpu_clk   (clk),
    .cpu_rst   (rst),
    .Bus_addr  (addr),
    .Bus_wen   (wen),
    .Bus_wdata (wdata),
    .Bus_rdata (rdata),
    .dram_addr (dram_addr),
    .dram_wen  (dram_wen),
    .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .sw        (sw),
    .led       (led),
    .dig_en    (dig_en),
    .dig_seg   (dig_seg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_RDATA: probe = rdata;
      S_DWEN:  probe = 32'(dram_wen);
      S_DADDR: probe = 32'(dram_addr);
      S_DWDAT: probe = dram_wdata;
      S_LED:   probe = 32'(led);
      S_DEN:   probe = 32'(dig_en);
      default: probe = 32'(dig_seg);
    endcase
  endfunction

  task automatic exp_at(input int sel, input logic [31:0] val, input string nm,
                        input int unsigned c);
    chk_t n;
    int   i;
    n.cyc = c; n.sel = sel; n.val = val; n.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, n);
  endtask

  task automatic ex(input int sel, input logic [31:0] val, input string nm,
                    input int unsigned n);
    exp_at(sel, val, nm, base + n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int unsigned n);
    while (cyc < base + n) step();
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr = a; wen = w; wdata = d;
  endtask

  // Monitor: compare every entry that falls due this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_total++;
      if (e.cyc != cyc) begin
        $display("FAIL %s: check due at cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else begin
        act = probe(e.sel);
        if (act === e.val) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus(32'd0, 1'b0, 32'd0);
    sw = 24'h00F00F;
    dram_rdata = 32'hDEADBEEF;
    step(); step();

    // Reset: peripheral writes blocked, dram_wen still decoded
    bus(A_LED, 1'b1, 32'h55);
    exp_at(S_DWEN, 32'd0, "rst_periph_dram_wen", cyc);
    step();
    bus(32'h100, 1'b1, 32'h99);
    exp_at(S_DWEN, 32'd1, "rst_dram_wen", cyc);
    exp_at(S_DADDR, 32'h40, "rst_dram_addr", cyc);
    step();
    bus(32'd0, 1'b0, 32'd0);
    exp_at(S_LED, 32'd0, "rst_led", cyc);
    exp_at(S_DEN, 32'hFF, "rst_dig_en", cyc);
    exp_at(S_DSEG, 32'hFF, "rst_dig_seg", cyc);
    step();
    base = cyc;
    rst = 1'b0;
    ex(S_DEN, 32'hFF, "dig_en_before_scan", 0);
    ex(S_LED, 32'd0, "led_write_ignored_in_reset", 0);

    // Scan schedule: slot k shows from base+1+4k
    ex(S_DEN, 32'hFE, "slot0_en", 1);
    ex(S_DSEG, 32'hC0, "slot0_seg_dig0", 1);
    ex(S_DSEG, 32'hC0, "slot0_seg_no_restart", 2);
    ex(S_DEN, 32'hFE, "slot0_en_held", 4);
    ex(S_DEN, 32'hFD, "slot1_en", 5);
    ex(S_DSEG, 32'h80, "slot1_seg_8", 5);
    ex(S_DEN, 32'hFB, "slot2_en", 9);
    ex(S_DSEG, 32'hC0, "slot2_seg_0", 9);
    ex(S_DEN, 32'h7F, "slot7_en", 29);
    ex(S_DEN, 32'hFE, "wrap_slot0_en", 33);
    ex(S_DSEG, 32'h8E, "wrap_slot0_seg_F", 33);

    at(1);
    bus(A_DIG, 1'b1, 32'h0000008F);
    ex(S_DWEN, 32'd0, "dig_write_dram_wen", 1);
    ex(S_RDATA, 32'd0, "dig_read_before_write", 1);
    at(2);
    bus(A_DIG, 1'b0, 32'd0);
    ex(S_RDATA, 32'h8F, "dig_readback", 2);

    at(3);
    bus(32'h10, 1'b1, 32'h12345678);
    ex(S_DWEN, 32'd1, "dram_write_wen", 3);
    ex(S_DADDR, 32'd4, "dram_write_addr", 3);
    ex(S_DWDAT, 32'h12345678, "dram_write_data", 3);
    ex(S_RDATA, 32'hDEADBEEF, "dram_read_data", 3);
    at(4);
    bus(A_LED, 1'b1, 32'h00ABCDEF);
    ex(S_DWEN, 32'd0, "led_write_dram_wen", 4);
    ex(S_LED, 32'd0, "led_unchanged_by_dram", 4);
    at(5);
    bus(A_LED, 1'b0, 32'd0);
    ex(S_RDATA, 32'h00ABCDEF, "led_readback", 5);
    ex(S_LED, 32'h00ABCDEF, "led_port", 5);

    at(6);
    bus(A_SW, 1'b1, 32'hFFFFFFFF);
    ex(S_RDATA, 32'h0000F00F, "sw_read", 6);
    ex(S_DWEN, 32'd0, "sw_write_dram_wen", 6);
    at(7);
    bus(A_SW, 1'b0, 32'd0);
    ex(S_RDATA, 32'h0000F00F, "sw_after_write", 7);
    ex(S_LED, 32'h00ABCDEF, "led_after_sw_write", 7);

    at(8);
    bus(A_UNMAP, 1'b1, 32'h1234);
    ex(S_RDATA, 32'd0, "unmapped_read", 8);
    ex(S_DWEN, 32'd0, "unmapped_dram_wen", 8);
    at(9);
    bus(A_UNMAP, 1'b0, 32'd0);
    ex(S_RDATA, 32'd0, "unmapped_after_write", 9);
    ex(S_LED, 32'h00ABCDEF, "led_after_unmapped", 9);

`ifdef MMIO_BRIDGE_TIMER_EN
    at(10);
    bus(A_TDIV, 1'b1, 32'd3);
    at(11);
    bus(A_TIMER, 1'b1, 32'hFFFFFFFE);
    at(12);
    bus(A_TIMER, 1'b0, 32'd0);
    ex(S_RDATA, 32'hFFFFFFFE, "timer_load", 12);
    ex(S_RDATA, 32'hFFFFFFFE, "timer_before_tick", 14);
    ex(S_RDATA, 32'hFFFFFFFF, "timer_tick1", 15);
    ex(S_RDATA, 32'hFFFFFFFF, "timer_hold", 17);
    ex(S_RDATA, 32'd0, "timer_wrap", 18);
    at(20);
    bus(A_TIMER, 1'b1, 32'h55AA);
    ex(S_RDATA, 32'd0, "timer_before_tick_write", 20);
    at(21);
    bus(A_TIMER, 1'b0, 32'd0);
    ex(S_RDATA, 32'h55AA, "timer_write_wins", 21);
    ex(S_RDATA, 32'h55AA, "timer_prescale_cleared", 23);
    ex(S_RDATA, 32'h55AB, "timer_tick_after_write", 24);
    at(25);
    bus(A_TDIV, 1'b0, 32'd0);
    ex(S_RDATA, 32'd3, "tdiv_readback", 25);
`else
    at(10);
    bus(A_TDIV, 1'b1, 32'd3);
    at(11);
    bus(A_TDIV, 1'b0, 32'd0);
    ex(S_RDATA, 32'd0, "tdiv_reads_zero", 11);
    at(12);
    bus(A_TIMER, 1'b1, 32'hFFFFFFFE);
    ex(S_RDATA, 32'd0, "timer_reads_zero", 12);
    at(13);
    bus(A_TIMER, 1'b0, 32'd0);
    ex(S_RDATA, 32'd0, "timer_write_ignored", 13);
    ex(S_RDATA, 32'd0, "timer_stays_zero", 20);
`endif

    at(38);
    ex(S_LED, 32'h00ABCDEF, "led_before_reset", 38);

    // Reset pulse mid-scan and mid-count
    at(40);
    rst = 1'b1;
    bus(A_LED, 1'b1, 32'h777);
    ex(S_DWEN, 32'd0, "reset_pulse_dram_wen", 40);
    at(41);
    rst = 1'b0;
    bus(A_TIMER, 1'b0, 32'd0);
    ex(S_DEN, 32'hFF, "pulse_dig_en", 41);
    ex(S_DSEG, 32'hFF, "pulse_dig_seg", 41);
    ex(S_LED, 32'd0, "pulse_led", 41);
    ex(S_RDATA, 32'd0, "pulse_timer", 41);
    at(42);
    bus(A_DIG, 1'b0, 32'd0);
    ex(S_DEN, 32'hFE, "resume_slot0_en", 42);
    ex(S_DSEG, 32'hC0, "resume_slot0_seg", 42);
    ex(S_RDATA, 32'd0, "pulse_dig_cleared", 42);
    ex(S_LED, 32'd0, "led_write_ignored_pulse", 42);
    ex(S_DEN, 32'hFE, "resume_slot0_held", 45);
    ex(S_DEN, 32'hFD, "resume_slot1_en", 46);

    at(50);
    for (int k = 0; k < 100 && sb.size() > 0; k++) step();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      $display("FAIL %s: check never sampled (due cycle %0d)", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
